// File: rtl/countdown_timer.sv
// Prescaled down-counter with IDLE/RUN/DONE control, one-shot or auto-reload operation,
// and a registered one-cycle terminal-count pulse.
module countdown_timer #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [PSC_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [PSC_W-1:0] r_psc;
    logic             r_tc;
    logic             w_tick;

    // Live compare so a prescale reduced below the running prescaler ticks at once.
    assign w_tick = (r_psc >= prescale);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values and simulation matches the synthesised flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_psc    <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (load) begin
                r_count  <= load_val;
                r_reload <= load_val;
                r_psc    <= '0;
                r_state  <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !stop && (r_count != '0)) begin
                            r_state <= S_RUN;
                            r_psc   <= '0;
                        end
                    end
                    S_DONE: begin
                        if (start) begin
                            r_count <= r_reload;
                            r_psc   <= '0;
                            r_state <= (r_reload != '0) ? S_RUN : S_IDLE;
                        end
                    end
                    S_RUN: begin
                        if (stop) begin
                            r_state <= S_IDLE;
                            r_psc   <= '0;
                        end else if (!w_tick) begin
                            r_psc <= r_psc + PSC_ONE;
                        end else begin
                            r_psc <= '0;
                            if (r_count > CNT_ONE) begin
                                r_count <= r_count - CNT_ONE;
                            end else if (r_count == CNT_ONE) begin
                                // Terminal tick: auto_reload is only consulted here.
                                r_tc <= 1'b1;
                                if (auto_reload) begin
                                    r_count <= r_reload;
                                end else begin
                                    r_count <= '0;
                                    r_state <= S_DONE;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios plus random traffic, each cycle's
// expected outputs come from a behavioural model and are checked by an independent monitor.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] prescale = '0;
    logic [7:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    countdown_timer #(.WIDTH(8), .PSC_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .prescale    (prescale),
        .count       (count),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] count;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        bit rs;
        bit ld;
        int lv;
        bit st;
        bit sp;
        bit ar;
        int ps;
    } stim_t;

    typedef enum int {M_IDLE, M_RUN, M_DONE} mode_t;

    exp_t  exp_q[$];
    stim_t cur;
    int    checks = 0;
    int    failures = 0;

    // Reference model: timer described in terms of remaining count, reload value and
    // cycles elapsed since the last tick.
    mode_t m_mode = M_IDLE;
    int    m_cnt = 0;
    int    m_rel = 0;
    int    m_elapsed = 0;
    bit    m_tc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input stim_t s);
        m_tc = 1'b0;
        if (s.rs) begin
            m_mode = M_IDLE; m_cnt = 0; m_rel = 0; m_elapsed = 0;
        end else if (s.ld) begin
            m_mode = M_IDLE; m_cnt = s.lv; m_rel = s.lv; m_elapsed = 0;
        end else if (m_mode == M_IDLE) begin
            if (s.st && !s.sp && m_cnt != 0) begin
                m_mode = M_RUN; m_elapsed = 0;
            end
        end else if (m_mode == M_DONE) begin
            if (s.st) begin
                m_cnt = m_rel; m_elapsed = 0;
                m_mode = (m_rel != 0) ? M_RUN : M_IDLE;
            end
        end else if (s.sp) begin
            m_mode = M_IDLE; m_elapsed = 0;
        end else if (m_elapsed < s.ps) begin
            m_elapsed++;
        end else begin
            m_elapsed = 0;
            if (m_cnt > 1) begin
                m_cnt--;
            end else if (m_cnt == 1) begin
                m_tc = 1'b1;
                if (s.ar) m_cnt = m_rel;
                else begin
                    m_cnt = 0; m_mode = M_DONE;
                end
            end
        end
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        @(negedge clk);
        #1;
        // NOTE: bench inputs are driven with blocking assignments, half a cycle from the edge.
        reset       = s.rs;
        load        = s.ld;
        load_val    = s.lv[7:0];
        start       = s.st;
        stop        = s.sp;
        auto_reload = s.ar;
        prescale    = s.ps[3:0];
        model_step(s);
        e.count = m_cnt[7:0];
        e.tc    = m_tc;
        e.busy  = (m_mode == M_RUN);
        e.done  = (m_mode == M_DONE);
        exp_q.push_back(e);
    endtask

    task automatic step();
        apply(cur);
        cur.ld = 1'b0;
        cur.st = 1'b0;
        cur.sp = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count", 32'(count), 32'(e.count));
                check("tc",    32'(tc),    32'(e.tc));
                check("busy",  32'(busy),  32'(e.busy));
                check("done",  32'(done),  32'(e.done));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        cur.rs = 1'b0; cur.ld = 1'b0; cur.lv = 0; cur.st = 1'b0;
        cur.sp = 1'b0; cur.ar = 1'b0; cur.ps = 0;

        #1 reset = 1'b1;
        #1;
        check("reset_count", 32'(count), 0);
        check("reset_flags", {29'd0, tc, busy, done}, 0);
        cur.rs = 1'b1;
        idle(2);
        cur.rs = 1'b0;

        // One-shot from 5, prescale 0
        cur.ar = 1'b0; cur.ps = 0; cur.ld = 1'b1; cur.lv = 5;
        step();
        cur.st = 1'b1;
        step();
        idle(6);
        #1;
        check("oneshot_final_count", 32'(count), 0);
        check("oneshot_tc_at_zero", 32'(tc), 1);
        check("oneshot_done", {30'd0, busy, done}, 1);
        step();
        #1;
        check("oneshot_tc_single", 32'(tc), 0);

        // Auto-reload from 3, prescale 2
        cur.ar = 1'b1; cur.ps = 2; cur.ld = 1'b1; cur.lv = 3;
        step();
        cur.st = 1'b1;
        step();
        idle(30);
        #1;
        check("autoreload_busy", 32'(busy), 1);
        cur.sp = 1'b1;
        step();

        // Pause and resume
        cur.ar = 1'b0; cur.ps = 1; cur.ld = 1'b1; cur.lv = 10;
        step();
        cur.st = 1'b1;
        step();
        for (int i = 0; i < 40 && m_cnt != 7; i++) step();
        cur.sp = 1'b1;
        step();
        idle(10);
        #1;
        check("paused_count", 32'(count), 7);
        check("paused_busy", 32'(busy), 0);
        cur.st = 1'b1;
        step();
        idle(4);

        // Start with zero count, load+start together, start+stop together
        cur.ld = 1'b1; cur.lv = 0;
        step();
        cur.st = 1'b1;
        step();
        idle(2);
        #1;
        check("zero_start_busy", 32'(busy), 0);
        cur.ld = 1'b1; cur.lv = 4; cur.st = 1'b1;
        step();
        idle(1);
        #1;
        check("load_start_count", 32'(count), 4);
        check("load_start_busy", 32'(busy), 0);
        cur.st = 1'b1; cur.sp = 1'b1;
        step();
        idle(1);
        #1;
        check("start_stop_busy", 32'(busy), 0);

        // Reload value 1 in auto-reload: tc every cycle
        cur.ar = 1'b1; cur.ps = 0; cur.ld = 1'b1; cur.lv = 1;
        step();
        cur.st = 1'b1;
        step();
        idle(2);
        for (int i = 0; i < 8; i++) begin
            step();
            #1;
            check("r1_tc_every_cycle", 32'(tc), 1);
            check("r1_count", 32'(count), 1);
        end
        cur.sp = 1'b1;
        step();

        // Asynchronous reset mid-run
        cur.ar = 1'b0; cur.ps = 0; cur.ld = 1'b1; cur.lv = 6;
        step();
        cur.st = 1'b1;
        step();
        idle(2);
        cur.rs = 1'b1;
        step();
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_flags", {29'd0, tc, busy, done}, 0);
        step();
        cur.rs = 1'b0;
        cur.st = 1'b1;
        step();
        idle(2);
        #1;
        check("post_rst_start_ignored", 32'(busy), 0);
        cur.ld = 1'b1; cur.lv = 3;
        step();
        cur.st = 1'b1;
        step();
        idle(5);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cur.rs = ($urandom_range(0, 299) == 0);
            cur.ld = ($urandom_range(0, 99) < 4);
            cur.lv = $urandom_range(0, 6);
            cur.st = ($urandom_range(0, 99) < 12);
            cur.sp = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 5) cur.ar = ~cur.ar;
            if ($urandom_range(0, 99) < 3) cur.ps = $urandom_range(0, 3);
            step();
        end
        cur.rs = 1'b0;
        idle(2);

        @(negedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of load_val, count and the reload register.
REQ-002 SHALL have parameter PSC_W, default 4: width of prescale.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous reset, active-high.
REQ-005 SHALL have port load, input, 1: load count and reload register from load_val.
REQ-006 SHALL have port load_val, input, WIDTH: start/reload value.
REQ-007 SHALL have port start, input, 1: begin or resume counting.
REQ-008 SHALL have port stop, input, 1: pause counting.
REQ-009 SHALL have port auto_reload, input, 1: reload on terminal count instead of halting.
REQ-010 SHALL have port prescale, input, PSC_W: one count tick every prescale+1 clk cycles.
REQ-011 SHALL have port count, output, WIDTH: registered current count value.
REQ-012 SHALL have port tc, output, 1: registered one-cycle terminal-count pulse.
REQ-013 SHALL have port busy, output, 1: high while in RUN.
REQ-014 SHALL have port done, output, 1: high while in DONE.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; busy=(RUN), done=(DONE), both registered/state-decoded, no combinational input-to-output paths.
REQ-016 SHALL, on load in any state, set count and reload register R to load_val, clear prescaler, enter IDLE, drive tc=0 next cycle; load has priority over start, stop and ticks.
REQ-017 SHALL, on start in IDLE with count!=0 and no load/stop, enter RUN with prescaler cleared; start with count==0 is ignored.
REQ-018 SHALL, on start in DONE, set count<=R and enter RUN if R!=0, else stay IDLE with count 0.
REQ-019 SHALL, on stop in RUN, enter IDLE holding count and clearing prescaler; stop wins over simultaneous start.
REQ-020 SHALL, in RUN, increment prescaler each cycle; tick when prescaler>=prescale (live compare, tolerates mid-run change), prescaler then returns to 0.
REQ-021 SHALL, on tick with count>1, decrement count by 1 (no wrap).
REQ-022 SHALL, on tick with count==1 and auto_reload=1, set count<=R, stay RUN, pulse tc for exactly the following cycle.
REQ-023 SHALL, on tick with count==1 and auto_reload=0, set count<=0, enter DONE, pulse tc for exactly the following cycle.
REQ-024 SHALL give period R*(prescale+1) clk cycles in auto_reload mode; R==1 yields tc on every tick.
REQ-025 SHALL sample auto_reload only at the terminal tick; changes elsewhere have no effect.
REQ-026 SHALL hold all state in IDLE and DONE except as driven by load/start.

Reset
REQ-027 SHALL, while reset high, force count=0, R=0, prescaler=0, state IDLE, tc=0, busy=0, done=0, regardless of clk.
REQ-028 SHALL, on reset asserted mid-RUN, abort immediately with no tc pulse; first edge after release behaves as from IDLE.

Verification
REQ-029 SHALL test: load_val=5, load, prescale=0, auto_reload=0, start -> count 4,3,2,1,0 on consecutive edges, tc high exactly in cycle count reads 0, done=1, busy=0.
REQ-030 SHALL test: load_val=3, prescale=2, auto_reload=1, start -> count 3,2,1,3,... each value held 3 cycles, tc every 9 cycles, busy stays 1.
REQ-031 SHALL test: load 10, run to count 7, stop 10 cycles, start -> count frozen at 7 while paused, resumes 6 after prescale+1 cycles.
REQ-032 SHALL test: start with count 0 -> stays IDLE; load_val=4 with load and start same cycle -> count=4, IDLE; start+stop same cycle in IDLE -> stays IDLE.
REQ-033 SHALL test: load 1, auto_reload=1, prescale=0, start -> tc high every cycle, count stays 1.
REQ-034 SHALL test: reset asserted mid-RUN between edges -> count=0, busy=0, tc=0 immediately; after release, start ignored until load.
